// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter for instruction fetch and load/store
//
// Shares one unified single-port memory between the fetch stage (read-only)
// and the MEM stage (load/store). At most one memory transaction is in flight.
// A watchdog aborts any transaction the memory never acknowledges.
//
// Parameters:
//   AW      address width
//   DW      data width
//   TIMEOUT BUSY cycles allowed before a transaction is aborted (>= 2)
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   if_req_i/if_addr_i      fetch request, held until if_ack_o
//   if_ack_o/if_rdata_o     one-cycle fetch completion and instruction word
//   d_req_i/d_we_i/d_addr_i/d_wdata_i  data request (load or store), held until d_ack_o
//   d_ack_o/d_rdata_o       one-cycle data completion and load data
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o  memory request, held until mem_ack_i
//   mem_ack_i/mem_rdata_i   memory completion and read data
//   stall_o                 combinational pipeline freeze
//   timeout_o               sticky watchdog error flag, cleared only by rst_i
//
// Build option:
//   ARB_RR_EN  alternate between ports on simultaneous requests instead of
//              fixed data-over-fetch priority.

module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,

  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic          if_ack_o,
  output logic [DW-1:0] if_rdata_o,

  input  logic          d_req_i,
  input  logic          d_we_i,
  input  logic [AW-1:0] d_addr_i,
  input  logic [DW-1:0] d_wdata_i,
  output logic          d_ack_o,
  output logic [DW-1:0] d_rdata_o,

  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic          mem_ack_i,
  input  logic [DW-1:0] mem_rdata_i,

  output logic          stall_o,
  output logic          timeout_o
);

  // Counter must hold values 0 .. TIMEOUT-1.
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LP_CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [DW-1:0] LP_ERR_DATA = DW'(32'hDEAD_BEEF);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_wait_cnt;
  logic          r_mem_req;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic          r_if_ack;
  logic [DW-1:0] r_if_rdata;
  logic          r_d_ack;
  logic [DW-1:0] r_d_rdata;
  logic          r_timeout;

`ifdef ARB_RR_EN
  // 0 = fetch was granted last, 1 = data was granted last.
  logic          r_last_grant_d;
`endif

  logic w_if_elig;
  logic w_d_elig;
  logic w_grant_d;
  logic w_grant_i;
  logic w_busy;
  logic w_done;
  logic w_expire;
  logic [DW-1:0] w_fin_data;

  // A request still high in its own ack cycle is the stale tail of the
  // transaction that just finished, not a new request.
  assign w_if_elig = if_req_i & ~r_if_ack;
  assign w_d_elig  = d_req_i  & ~r_d_ack;

`ifdef ARB_RR_EN
  // Contested: hand the grant to whichever port did not win last time.
  assign w_grant_d = w_d_elig & (~w_if_elig | ~r_last_grant_d);
`else
  // Data port wins ties: the MEM stage holds the older instruction.
  assign w_grant_d = w_d_elig;
`endif
  assign w_grant_i = w_if_elig & ~w_grant_d;

  assign w_busy     = (r_state == ST_BUSY_I) || (r_state == ST_BUSY_D);
  // A real acknowledge on the last allowed cycle beats the watchdog.
  assign w_done     = w_busy & mem_ack_i;
  assign w_expire   = w_busy & ~mem_ack_i & (r_wait_cnt == LP_CNT_LAST);
  assign w_fin_data = mem_ack_i ? mem_rdata_i : LP_ERR_DATA;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_wait_cnt  <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_ack    <= 1'b0;
      r_if_rdata  <= '0;
      r_d_ack     <= 1'b0;
      r_d_rdata   <= '0;
      r_timeout   <= 1'b0;
`ifdef ARB_RR_EN
      r_last_grant_d <= 1'b0;
`endif
    end else begin
      // Completion pulses last exactly one cycle.
      r_if_ack <= 1'b0;
      r_d_ack  <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          // Acknowledges arriving here are late or spurious and are ignored.
          r_wait_cnt <= '0;
          if (w_grant_d) begin
            r_state     <= ST_BUSY_D;
            r_mem_req   <= 1'b1;
            r_mem_we    <= d_we_i;
            r_mem_addr  <= d_addr_i;
            r_mem_wdata <= d_wdata_i;
`ifdef ARB_RR_EN
            r_last_grant_d <= 1'b1;
`endif
          end else if (w_grant_i) begin
            r_state     <= ST_BUSY_I;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= if_addr_i;
            r_mem_wdata <= '0;
`ifdef ARB_RR_EN
            r_last_grant_d <= 1'b0;
`endif
          end
        end

        ST_BUSY_I, ST_BUSY_D: begin
          if (w_done || w_expire) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            if (w_expire) begin
              r_timeout <= 1'b1;
            end
            if (r_state == ST_BUSY_I) begin
              r_if_ack   <= 1'b1;
              r_if_rdata <= w_fin_data;
            end else begin
              r_d_ack <= 1'b1;
              // A completed store leaves the load-data register untouched;
              // an aborted one still reports the error pattern.
              if (!r_mem_we || w_expire) begin
                r_d_rdata <= w_fin_data;
              end
            end
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end

        default: begin
          r_state    <= ST_IDLE;
          r_mem_req  <= 1'b0;
          r_mem_we   <= 1'b0;
          r_wait_cnt <= '0;
        end
      endcase
    end
  end

  assign if_ack_o    = r_if_ack;
  assign if_rdata_o  = r_if_rdata;
  assign d_ack_o     = r_d_ack;
  assign d_rdata_o   = r_d_rdata;
  assign mem_req_o   = r_mem_req;
  assign mem_we_o    = r_mem_we;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;
  assign timeout_o   = r_timeout;

  // Combinational so the pipeline freezes in the same cycle a request appears.
  assign stall_o = (if_req_i & ~r_if_ack) | (d_req_i & ~r_d_ack);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int TO = 4;
`ifdef ARB_RR_EN
  localparam bit I_FIRST = 1'b1;
`else
  localparam bit I_FIRST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_ack_o;
  logic [31:0] if_rdata_o;
  logic        d_req_i;
  logic        d_we_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic        d_ack_o;
  logic [31:0] d_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        stall_o;
  logic        timeout_o;

  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ack_o(if_ack_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_ack_o(d_ack_o), .d_rdata_o(d_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .stall_o(stall_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory: acknowledges on the lat-th cycle of a request; lat beyond TO never acks.
  bit          rand_mem = 1'b0;
  int          mem_lat = 1;
  bit          spur = 1'b0;
  logic [31:0] dir_rdata = 32'h0;
  int          m_cnt = 0;
  int          m_cur = 1;

  initial begin
    mem_ack_i   = 1'b0;
    mem_rdata_i = 32'h0;
  end

  always @(posedge clk) begin
    #1;
    mem_rdata_i = rand_mem ? $urandom : dir_rdata;
    if (mem_req_o === 1'b1) begin
      m_cnt++;
      if (m_cnt == 1)
        m_cur = !rand_mem ? mem_lat :
                ($urandom_range(0, 6) == 0) ? 100 : int'($urandom_range(1, 5));
      mem_ack_i = (m_cnt == m_cur);
    end else begin
      m_cnt = 0;
      mem_ack_i = rand_mem ? ($urandom_range(0, 9) == 0) : spur;
    end
  end

  // Transaction-level reference: who owns the memory and for how many cycles.
  int          m_owner = 0;      // 0 free, 1 fetch, 2 data
  int          m_elapsed = 0;    // BUSY cycles spent on the current transaction
  int          m_last = 1;       // port granted most recently
  int          g;
  bit          want_i, want_d;
  logic [31:0] fin;
  logic        e_mem_req = 0, e_mem_we = 0, e_if_ack = 0, e_d_ack = 0, e_timeout = 0;
  logic [31:0] e_mem_addr = 0, e_mem_wdata = 0, e_if_rdata = 0, e_d_rdata = 0;

  always @(posedge clk) begin
    if (rst_i === 1'b1) begin
      m_owner = 0; m_elapsed = 0; m_last = 1;
      e_mem_req = 0; e_mem_we = 0; e_if_ack = 0; e_d_ack = 0; e_timeout = 0;
      e_mem_addr = 0; e_mem_wdata = 0; e_if_rdata = 0; e_d_rdata = 0;
    end else begin
      want_i = if_req_i && !e_if_ack;
      want_d = d_req_i && !e_d_ack;
      e_if_ack = 0;
      e_d_ack  = 0;
      if (m_owner == 0) begin
        g = 0;
        if (want_i && want_d) g = I_FIRST ? ((m_last == 1) ? 2 : 1) : 2;
        else if (want_d)      g = 2;
        else if (want_i)      g = 1;
        if (g != 0) begin
          m_owner = g; m_elapsed = 0; m_last = g;
          e_mem_req   = 1;
          e_mem_we    = (g == 2) && d_we_i;
          e_mem_addr  = (g == 2) ? d_addr_i : if_addr_i;
          e_mem_wdata = (g == 2) ? d_wdata_i : 32'h0;
        end
      end else begin
        m_elapsed++;
        if (mem_ack_i || m_elapsed == TO) begin
          fin = mem_ack_i ? mem_rdata_i : 32'hDEAD_BEEF;
          if (!mem_ack_i) e_timeout = 1;
          if (m_owner == 1) begin
            e_if_ack = 1; e_if_rdata = fin;
          end else begin
            e_d_ack = 1;
            if (!e_mem_we || !mem_ack_i) e_d_rdata = fin;
          end
          e_mem_req = 0; e_mem_we = 0; m_owner = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk1 ("cyc mem_req_o",   mem_req_o,   e_mem_req);
      chk1 ("cyc mem_we_o",    mem_we_o,    e_mem_we);
      chk32("cyc mem_addr_o",  mem_addr_o,  e_mem_addr);
      chk32("cyc mem_wdata_o", mem_wdata_o, e_mem_wdata);
      chk1 ("cyc if_ack_o",    if_ack_o,    e_if_ack);
      chk32("cyc if_rdata_o",  if_rdata_o,  e_if_rdata);
      chk1 ("cyc d_ack_o",     d_ack_o,     e_d_ack);
      chk32("cyc d_rdata_o",   d_rdata_o,   e_d_rdata);
      chk1 ("cyc timeout_o",   timeout_o,   e_timeout);
      chk1 ("cyc stall_o",     stall_o,     (if_req_i & ~e_if_ack) | (d_req_i & ~e_d_ack));
    end
  end

  bit i_drop, d_drop;

  initial begin
    rst_i = 1; if_req_i = 0; if_addr_i = 0; d_req_i = 0; d_we_i = 0; d_addr_i = 0; d_wdata_i = 0;
    repeat (2) step();
    rst_i = 0;
    cmp_en = 1;
    @(negedge clk);
    chk1 ("reset mem_req_o", mem_req_o, 1'b0);
    chk1 ("reset timeout_o", timeout_o, 1'b0);
    chk32("reset d_rdata_o", d_rdata_o, 32'h0);
    chk1 ("reset stall_o",   stall_o,   1'b0);

    // Fetch alone, memory acks in the first BUSY cycle.
    step(); mem_lat = 1; dir_rdata = 32'h0010_0093; if_addr_i = 32'h10; if_req_i = 1;
    @(negedge clk); chk1("fetch c0 stall", stall_o, 1'b1); chk1("fetch c0 mem_req", mem_req_o, 1'b0);
    step();
    @(negedge clk); chk1("fetch c1 mem_req", mem_req_o, 1'b1); chk32("fetch c1 addr", mem_addr_o, 32'h10);
    chk1("fetch c1 we", mem_we_o, 1'b0); chk1("fetch c1 stall", stall_o, 1'b1);
    step();
    @(negedge clk); chk1("fetch c2 ack", if_ack_o, 1'b1); chk32("fetch c2 rdata", if_rdata_o, 32'h0010_0093);
    chk32("model fetch rdata", e_if_rdata, 32'h0010_0093); chk1("fetch c2 stall", stall_o, 1'b0);
    step(); if_req_i = 0;
    @(negedge clk); chk1("fetch c3 ack", if_ack_o, 1'b0); chk1("fetch c3 no regrant", mem_req_o, 1'b0);

    // Store with a 3-cycle memory.
    step(); mem_lat = 3; d_we_i = 1; d_addr_i = 32'h100; d_wdata_i = 32'hCAFE_F00D; d_req_i = 1;
    for (int k = 1; k <= 3; k++) begin
      step();
      @(negedge clk); chk1("store busy we", mem_we_o, 1'b1); chk32("store busy wdata", mem_wdata_o, 32'hCAFE_F00D);
      chk1("store busy ack", d_ack_o, 1'b0);
    end
    step();
    @(negedge clk); chk1("store ack", d_ack_o, 1'b1); chk32("store d_rdata", d_rdata_o, 32'h0);
    chk1("model store ack", e_d_ack, 1'b1);
    step(); d_req_i = 0;
    @(negedge clk); chk1("store ack one cycle", d_ack_o, 1'b0);

    // Simultaneous requests, immediate acks.
    step(); mem_lat = 1; dir_rdata = 32'h1234_5678; d_we_i = 0;
    if_addr_i = 32'h20; d_addr_i = 32'h200; if_req_i = 1; d_req_i = 1;
    step();
    @(negedge clk); chk32("simul first addr", mem_addr_o, I_FIRST ? 32'h20 : 32'h200);
    step();
    @(negedge clk); chk1("simul first d_ack", d_ack_o, !I_FIRST); chk1("simul first if_ack", if_ack_o, I_FIRST);
    step(); if (I_FIRST) if_req_i = 0; else d_req_i = 0;
    @(negedge clk); chk1("simul second req", mem_req_o, 1'b1);
    chk32("simul second addr", mem_addr_o, I_FIRST ? 32'h200 : 32'h20);
    step();
    @(negedge clk); chk1("simul second if_ack", if_ack_o, !I_FIRST); chk1("simul second d_ack", d_ack_o, I_FIRST);
    step(); if_req_i = 0; d_req_i = 0;

    // Watchdog: load that is never acknowledged.
    step(); mem_lat = 100; d_we_i = 0; d_addr_i = 32'h300; d_req_i = 1;
    for (int k = 1; k <= TO; k++) begin
      step();
      @(negedge clk); chk1("wd busy req", mem_req_o, 1'b1); chk1("wd busy ack", d_ack_o, 1'b0);
    end
    step();
    @(negedge clk); chk1("wd ack", d_ack_o, 1'b1); chk32("wd rdata", d_rdata_o, 32'hDEAD_BEEF);
    chk1("wd timeout", timeout_o, 1'b1); chk1("model wd timeout", e_timeout, 1'b1);
    step(); d_req_i = 0; spur = 1;
    repeat (3) begin
      step();
      @(negedge clk); chk1("spur no ack", d_ack_o, 1'b0); chk1("spur no req", mem_req_o, 1'b0);
      chk1("timeout sticky", timeout_o, 1'b1);
    end
    spur = 0;

    // Reset during the second BUSY_I cycle.
    step(); if_addr_i = 32'h40; if_req_i = 1;
    step();
    step(); rst_i = 1;
    step(); rst_i = 0; if_req_i = 0;
    @(negedge clk); chk1("rst mem_req", mem_req_o, 1'b0); chk1("rst if_ack", if_ack_o, 1'b0);
    chk1("rst timeout", timeout_o, 1'b0); chk32("rst d_rdata", d_rdata_o, 32'h0);
    chk32("rst mem_addr", mem_addr_o, 32'h0);

    // Randomized traffic against the model.
    rand_mem = 1; i_drop = 0; d_drop = 0;
    for (int c = 0; c < 4000; c++) begin
      step();
      if (rst_i) begin
        rst_i = 0;
      end else if ($urandom_range(0, 299) == 0) begin
        rst_i = 1; if_req_i = 0; d_req_i = 0; i_drop = 0; d_drop = 0;
      end else begin
        if (i_drop) begin
          if_req_i = 0; i_drop = 0;
        end else if (if_req_i) begin
          if (if_ack_o) i_drop = 1;
        end else if ($urandom_range(0, 2) == 0) begin
          if_addr_i = $urandom; if_req_i = 1;
        end
        if (d_drop) begin
          d_req_i = 0; d_drop = 0;
        end else if (d_req_i) begin
          if (d_ack_o) d_drop = 1;
        end else if ($urandom_range(0, 2) == 0) begin
          d_we_i = $urandom_range(0, 1); d_addr_i = $urandom; d_wdata_i = $urandom; d_req_i = 1;
        end
      end
    end
    rand_mem = 0; if_req_i = 0; d_req_i = 0;
    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch stage (read-only) and the MEM stage (load/store).
- Sits between the pipeline and the memory model.
- Serialises requests through a small FSM and drives the pipeline stall.
- Runs a watchdog so that a memory which never acknowledges cannot hang the core.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits.
- TIMEOUT, 16, maximum number of BUSY cycles waiting for mem_ack_i before abort (≥2).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- if_req_i  in  1  fetch request; held until if_ack_o.
- if_addr_i  in  AW  fetch address; stable while if_req_i is high.
- if_ack_o  out  1  one-cycle completion pulse for fetch.
- if_rdata_o  out  DW  fetched instruction word.
- d_req_i  in  1  data request; held until d_ack_o.
- d_we_i  in  1  1 = store, 0 = load.
- d_addr_i  in  AW  data address.
- d_wdata_i  in  DW  store data.
- d_ack_o  out  1  one-cycle completion pulse for data.
- d_rdata_o  out  DW  load data.
- mem_req_o  out  1  memory request; held until mem_ack_i.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  AW  memory address.
- mem_wdata_o  out  DW  memory write data.
- mem_ack_i  in  1  memory completion; valid only while mem_req_o is high.
- mem_rdata_i  in  DW  read data; valid with mem_ack_i.
- stall_o  out  1  pipeline freeze.
- timeout_o  out  1  sticky watchdog error flag.

Behaviour:
- States: IDLE, BUSY_I, BUSY_D. Reset → IDLE. All registered outputs reset to 0: mem_*, *_ack_o, *_rdata_o, timeout_o. Wait counter resets to 0.
- IDLE grant rules:
  - A request is eligible if x_req_i=1 and x_ack_o=0 in that cycle. The requester drops req the cycle after its ack, so the held-over req is ignored.
  - If both are eligible, D wins (fixed priority: the older instruction goes first).
- On grant:
  - Next state is BUSY_x.
  - At the same edge, register mem_addr_o, mem_we_o and mem_wdata_o from the granted port, and set mem_req_o=1.
  - Fetch grants force mem_we_o=0.
- BUSY_x:
  - mem_req_o and the address/data fields stay constant.
  - The wait counter increments every cycle.
- mem_ack_i=1 in BUSY_x, at the edge:
  - mem_req_o←0, mem_we_o←0, x_ack_o←1 for exactly one cycle, state←IDLE, counter←0.
  - On a read, x_rdata_o←mem_rdata_i.
  - On a store, d_rdata_o holds its previous value.
- Latency and throughput:
  - Minimum latency is req seen at cycle 0 → mem_req_o at cycle 1 → mem_ack_i at cycle 1 → x_ack_o at cycle 2.
  - The IDLE cycle coinciding with the ack pulse may grant the other port. Back-to-back alternating transactions therefore cost 2 cycles each.
- Watchdog:
  - Triggers when the counter reaches TIMEOUT-1 in BUSY without mem_ack_i.
  - At that edge: mem_req_o←0, x_ack_o←1 (one cycle), x_rdata_o←32'hDEAD_BEEF (read or write), timeout_o←1 (sticky until rst_i), state←IDLE.
  - If mem_ack_i arrives on the timeout cycle, ack wins and there is no error.
- mem_ack_i while in IDLE (late or spurious) is ignored; no output changes.
- stall_o = (if_req_i & ~if_ack_o) | (d_req_i & ~d_ack_o). This is combinational, so the pipeline freezes in the same cycle a request appears.
- rst_i mid-transaction:
  - The next edge forces IDLE and drops mem_req_o.
  - The pending transaction is abandoned with no ack pulse.
  - The memory must tolerate an abandoned request.
- Width rule: addresses and data pass through unmodified; no alignment checks.

Optional Feature:
- Macro ARB_RR_EN.
- When defined:
  - A 1-bit last_grant register, reset to I.
  - On simultaneous eligible requests in IDLE, grant the port not granted last; last_grant updates on every grant.
  - Single requests are granted immediately regardless of last_grant.
- When undefined: fixed D-over-I priority as above; no last_grant register.

Test Plan:
- Fetch alone: if_req_i=1, if_addr_i=0x0000_0010; memory acks in the first BUSY cycle with rdata 0x0010_0093 → mem_req_o high for 1 cycle with addr 0x10 and we=0; if_ack_o pulses at cycle 2; if_rdata_o=0x0010_0093; stall_o high for cycles 0-1.
- Store: d_req_i=1, d_we_i=1, addr 0x0000_0100, wdata 0xCAFE_F00D; memory acks after 3 cycles → mem_we_o=1 and mem_wdata_o=0xCAFE_F00D held for 3 cycles; d_ack_o pulses once; d_rdata_o unchanged (0).
- Simultaneous: if_req_i and d_req_i both rise in the same cycle, immediate acks → D is served first (d_ack_o at cycle 2); fetch is granted in the cycle of d_ack_o and if_ack_o follows 2 cycles later. With ARB_RR_EN, a second simultaneous pair is served I first.
- Timeout with TIMEOUT=4: d load with mem_ack_i never asserted → d_ack_o pulses after 4 BUSY cycles; d_rdata_o=0xDEAD_BEEF; timeout_o=1 and stays high until rst_i; a later mem_ack_i in IDLE is ignored.
- Reset mid-op: assert rst_i during the 2nd BUSY_I cycle → next edge mem_req_o=0, state IDLE, no if_ack_o pulse; all outputs are 0.
- Ack pulse discipline: hold if_req_i high for one cycle after if_ack_o (requester late to drop) → no second grant for that stale cycle.
